// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the ARM-subset core: FSM states, decoder operation
// codes, write-back select values and the operation-class record.
package cpu_ctrl_pkg;

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [31:0] OP_ADD  = 32'd0;
    localparam logic [31:0] OP_SUB  = 32'd2;
    localparam logic [31:0] OP_AND  = 32'd3;
    localparam logic [31:0] OP_ORR  = 32'd4;
    localparam logic [31:0] OP_EOR  = 32'd5;
    localparam logic [31:0] OP_MOV  = 32'd6;
    localparam logic [31:0] OP_MVN  = 32'd7;
    localparam logic [31:0] OP_CMP  = 32'd8;
    localparam logic [31:0] OP_TST  = 32'd9;
    localparam logic [31:0] OP_TEQ  = 32'd10;
    localparam logic [31:0] OP_BIC  = 32'd11;
    localparam logic [31:0] OP_CMPI = 32'd13;
    localparam logic [31:0] OP_B    = 32'd31;
    localparam logic [31:0] OP_BL   = 32'd32;
    localparam logic [31:0] OP_LDR  = 32'd41;
    localparam logic [31:0] OP_STR  = 32'd42;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;

    typedef struct packed {
        logic alu;
        logic cmp;
        logic branch;
        logic link;
        logic load;
        logic store;
        logic undef;
    } op_class_t;

endpackage

// File: rtl/cpu_ctrl_op_class.sv
// Combinational classifier: maps a decoder operation code onto exactly one
// operation class (ALU, compare, branch, branch-link, load, store, undefined).
module cpu_ctrl_op_class
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned CODE_W = 11
) (
    input  logic [CODE_W-1:0] code,
    output op_class_t         cls
);

    logic [31:0] code_ext;

    always_comb begin
        code_ext = 32'(code);
        cls      = '0;
        case (code_ext)
            OP_ADD, OP_SUB, OP_AND, OP_ORR,
            OP_EOR, OP_MOV, OP_MVN, OP_BIC:   cls.alu    = 1'b1;
            OP_CMP, OP_TST, OP_TEQ, OP_CMPI: cls.cmp    = 1'b1;
            OP_B:                            cls.branch = 1'b1;
            OP_BL:                           cls.link   = 1'b1;
            OP_LDR:                          cls.load   = 1'b1;
            OP_STR:                          cls.store  = 1'b1;
            default:                         cls.undef  = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the ARM-subset core.
// Optional CPU_CTRL_PERF_CNT_EN adds retired/skipped instruction counters.
module cpu_control_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned CODE_W      = 11,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              halt_req,
    input  logic              imem_ack,
    input  logic              dmem_ack,
    input  logic [CODE_W-1:0] alu_code,
    input  logic              execute_flag,
    input  logic              s_bit,
    output logic              imem_req,
    output logic              ir_write,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              reg_write,
    output logic [1:0]        wb_sel,
    output logic              cpsr_write,
    output logic              pc_write,
    output logic              pc_sel,
    output logic              halted,
    output logic              fault,
    output logic [2:0]        state_o
`ifdef CPU_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       skipped_cnt
`endif
);

    localparam int unsigned TO_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    logic [2:0]        state, state_nxt;
    logic [CODE_W-1:0] code_q;
    logic              exec_q, s_q, fault_q, fault_set;
    logic              fetch_wait, halt_entry, timed_out;
    logic [TO_W-1:0]   to_cnt;
    op_class_t         cls;

    cpu_ctrl_op_class #(.CODE_W(CODE_W)) u_op_class (
        .code (code_q),
        .cls  (cls)
    );

    // halt_req is only honoured in the first FETCH cycle, before any request
    assign halt_entry = (state == S_FETCH) && !fetch_wait && halt_req;
    assign timed_out  = (MEM_TIMEOUT > 0) && (to_cnt == TO_W'(MEM_TIMEOUT));
    assign fault      = fault_q;
    assign state_o    = state;

    always_comb begin
        state_nxt  = state;
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_write  = 1'b0;
        wb_sel     = WB_ALU;
        cpsr_write = 1'b0;
        pc_write   = 1'b0;
        pc_sel     = 1'b0;
        halted     = 1'b0;
        fault_set  = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    if (halt_entry) begin
                        state_nxt = S_HALT;
                    end else begin
                        imem_req = 1'b1;
                        if (imem_ack) begin
                            ir_write  = 1'b1;
                            state_nxt = S_DECODE;
                        end
                    end
                end
                S_DECODE: state_nxt = S_EXEC;
                S_EXEC: begin
                    state_nxt = S_FETCH;
                    if (!exec_q) begin
                        pc_write = 1'b1;
                    end else if (cls.undef) begin
                        fault_set = 1'b1;
                        pc_write  = 1'b1;
                    end else if (cls.alu) begin
                        state_nxt = S_WB;
                    end else if (cls.cmp) begin
                        cpsr_write = 1'b1;
                        pc_write   = 1'b1;
                    end else if (cls.branch || cls.link) begin
                        pc_write  = 1'b1;
                        pc_sel    = 1'b1;
                        reg_write = cls.link;
                        wb_sel    = cls.link ? WB_LINK : WB_ALU;
                    end else begin
                        state_nxt = S_MEM;
                    end
                end
                S_MEM: begin
                    if (timed_out) begin
                        fault_set = 1'b1;
                        pc_write  = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        dmem_req = 1'b1;
                        dmem_we  = cls.store;
                        if (dmem_ack) begin
                            pc_write  = cls.store;
                            state_nxt = cls.store ? S_FETCH : S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    wb_sel     = cls.load ? WB_MEM : WB_ALU;
                    cpsr_write = !cls.load && s_q;
                    pc_write   = 1'b1;
                    state_nxt  = S_FETCH;
                end
                S_HALT: begin
                    halted = 1'b1;
                    if (!halt_req) state_nxt = S_FETCH;
                end
                default: state_nxt = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            code_q     <= '0;
            exec_q     <= 1'b0;
            s_q        <= 1'b0;
            fault_q    <= 1'b0;
            fetch_wait <= 1'b0;
            to_cnt     <= '0;
        end else begin
            state      <= state_nxt;
            fetch_wait <= (state == S_FETCH) && (state_nxt == S_FETCH);
            if (state == S_DECODE) begin
                code_q <= alu_code;
                exec_q <= execute_flag;
                s_q    <= s_bit;
            end
            if (fault_set) fault_q <= 1'b1;
            if ((MEM_TIMEOUT > 0) && (state == S_MEM) && (state_nxt == S_MEM))
                to_cnt <= to_cnt + 1'b1;
            else
                to_cnt <= '0;
        end
    end

`ifdef CPU_CTRL_PERF_CNT_EN
    logic skip_now;
    assign skip_now = pc_write && (state == S_EXEC) && !exec_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_cnt <= '0;
            skipped_cnt <= '0;
        end else begin
            if (pc_write && !skip_now) retired_cnt <= retired_cnt + 32'd1;
            if (skip_now)              skipped_cnt <= skipped_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Randomized self-checking bench for cpu_control_fsm: per-instruction expected
// traces are built from the instruction-level rules and compared every cycle.
module tb_cpu_control_fsm;

    localparam int unsigned CODE_W = 11;
    localparam int unsigned TO     = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              halt_req = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0;
    logic [CODE_W-1:0] alu_code = '0;
    logic              execute_flag = 1'b0, s_bit = 1'b0;
    logic              imem_req, ir_write, dmem_req, dmem_we, reg_write;
    logic [1:0]        wb_sel;
    logic              cpsr_write, pc_write, pc_sel, halted, fault;
    logic [2:0]        state_o;
`ifdef CPU_CTRL_PERF_CNT_EN
    logic [31:0]       retired_cnt, skipped_cnt;
`endif

    cpu_control_fsm #(.CODE_W(CODE_W), .MEM_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .halt_req(halt_req), .imem_ack(imem_ack),
        .dmem_ack(dmem_ack), .alu_code(alu_code), .execute_flag(execute_flag),
        .s_bit(s_bit), .imem_req(imem_req), .ir_write(ir_write),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write),
        .wb_sel(wb_sel), .cpsr_write(cpsr_write), .pc_write(pc_write),
        .pc_sel(pc_sel), .halted(halted), .fault(fault), .state_o(state_o)
`ifdef CPU_CTRL_PERF_CNT_EN
        , .retired_cnt(retired_cnt), .skipped_cnt(skipped_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic halt, iack, dack, ef, s;
        logic [CODE_W-1:0] code;
    } in_t;

    typedef struct {
        logic imem_req, ir_write, dmem_req, dmem_we, reg_write;
        logic [1:0] wb_sel;
        logic cpsr_write, pc_write, pc_sel, halted, fault;
        logic [2:0] st;
        int unsigned ret, skp;
    } exp_t;

    localparam int K_ALU = 0, K_CMP = 1, K_B = 2, K_BL = 3, K_LDR = 4, K_STR = 5, K_UND = 6;

    in_t  in_q[$];
    exp_t ex_q[$];
    int   total = 0, bad = 0;
    logic m_fault = 1'b0;
    int unsigned m_ret = 0, m_skp = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, want);
        end
    endtask

    function automatic int kind(input int unsigned c);
        if (c inside {0, 2, 3, 4, 5, 6, 7, 11}) return K_ALU;
        if (c inside {8, 9, 10, 13}) return K_CMP;
        if (c == 31) return K_B;
        if (c == 32) return K_BL;
        if (c == 41) return K_LDR;
        if (c == 42) return K_STR;
        return K_UND;
    endfunction

    function automatic in_t junk();
        in_t r;
        r.halt = 1'($urandom); r.iack = 1'($urandom); r.dack = 1'($urandom);
        r.ef = 1'($urandom); r.s = 1'($urandom); r.code = CODE_W'($urandom);
        return r;
    endfunction

    function automatic exp_t blank(input int unsigned st);
        exp_t e;
        e = '{default: '0};
        e.st = 3'(st);
        return e;
    endfunction

    task automatic push(input in_t i, input exp_t e, input bit skip, input bit fset);
        e.fault = m_fault; e.ret = m_ret; e.skp = m_skp;
        in_q.push_back(i);
        ex_q.push_back(e);
        if (e.pc_write) begin
            if (skip) m_skp++; else m_ret++;
        end
        if (fset) m_fault = 1'b1;
    endtask

    // hh holds halt_req high after the first fetch cycle, which must not abort the instruction
    task automatic plan_instr(input logic [CODE_W-1:0] code, input logic ef, input logic s,
                              input int unsigned iw, input int unsigned dw, input logic hh);
        in_t i; exp_t e; int k;
        k = kind(int'(code));
        for (int n = 0; n <= int'(iw); n++) begin
            i = junk();
            i.halt = (n == 0) ? 1'b0 : (hh | i.halt);
            i.iack = (n == int'(iw));
            e = blank(0); e.imem_req = 1'b1; e.ir_write = (n == int'(iw));
            push(i, e, 0, 0);
        end
        i = junk(); i.code = code; i.ef = ef; i.s = s; i.halt = hh | i.halt;
        push(i, blank(1), 0, 0);
        i = junk(); i.halt = hh | i.halt;
        e = blank(2);
        if (!ef) begin e.pc_write = 1'b1; push(i, e, 1, 0); return; end
        case (k)
            K_CMP: begin e.cpsr_write = 1'b1; e.pc_write = 1'b1; end
            K_B:   begin e.pc_write = 1'b1; e.pc_sel = 1'b1; end
            K_BL:  begin e.pc_write = 1'b1; e.pc_sel = 1'b1; e.reg_write = 1'b1; e.wb_sel = 2'd2; end
            K_UND: begin e.pc_write = 1'b1; push(i, e, 0, 1); return; end
            default: ;
        endcase
        push(i, e, 0, 0);
        if (k == K_CMP || k == K_B || k == K_BL) return;
        if (k == K_LDR || k == K_STR) begin
            if (dw >= TO) begin
                for (int n = 0; n < int'(TO); n++) begin
                    i = junk(); i.dack = 1'b0; i.halt = hh | i.halt;
                    e = blank(3); e.dmem_req = 1'b1; e.dmem_we = (k == K_STR);
                    push(i, e, 0, 0);
                end
                i = junk(); i.halt = hh | i.halt;
                e = blank(3); e.pc_write = 1'b1;
                push(i, e, 0, 1);
                return;
            end
            for (int n = 0; n <= int'(dw); n++) begin
                i = junk(); i.dack = (n == int'(dw)); i.halt = hh | i.halt;
                e = blank(3); e.dmem_req = 1'b1; e.dmem_we = (k == K_STR);
                e.pc_write = (n == int'(dw)) && (k == K_STR);
                push(i, e, 0, 0);
            end
            if (k == K_STR) return;
        end
        i = junk(); i.halt = hh | i.halt;
        e = blank(4); e.reg_write = 1'b1; e.wb_sel = (k == K_LDR) ? 2'd1 : 2'd0;
        e.cpsr_write = (k == K_ALU) && s; e.pc_write = 1'b1;
        push(i, e, 0, 0);
    endtask

    task automatic plan_halt(input int unsigned n);
        in_t i; exp_t e;
        i = junk(); i.halt = 1'b1;
        push(i, blank(0), 0, 0);
        for (int j = 0; j <= int'(n); j++) begin
            i = junk(); i.halt = (j != int'(n));
            e = blank(5); e.halted = 1'b1;
            push(i, e, 0, 0);
        end
    endtask

    task automatic compare_cycle(input exp_t e);
        check("imem_req", imem_req, e.imem_req);
        check("ir_write", ir_write, e.ir_write);
        check("dmem_req", dmem_req, e.dmem_req);
        check("dmem_we", dmem_we, e.dmem_we);
        check("reg_write", reg_write, e.reg_write);
        check("wb_sel", wb_sel, e.wb_sel);
        check("cpsr_write", cpsr_write, e.cpsr_write);
        check("pc_write", pc_write, e.pc_write);
        check("pc_sel", pc_sel, e.pc_sel);
        check("halted", halted, e.halted);
        check("fault", fault, e.fault);
        check("state_o", state_o, e.st);
`ifdef CPU_CTRL_PERF_CNT_EN
        check("retired_cnt", retired_cnt, e.ret);
        check("skipped_cnt", skipped_cnt, e.skp);
`endif
    endtask

    // entered and left at posedge+1; outputs are sampled on the falling edge
    task automatic play(input int limit);
        in_t i; exp_t e;
        int n = 0;
        while (in_q.size() > 0 && n < limit) begin
            i = in_q.pop_front();
            e = ex_q.pop_front();
            halt_req = i.halt; imem_ack = i.iack; dmem_ack = i.dack;
            alu_code = i.code; execute_flag = i.ef; s_bit = i.s;
            @(negedge clk);
            compare_cycle(e);
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_fault = 1'b0; m_ret = 0; m_skp = 0;
    endtask

    int unsigned codes[21] = '{0, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 13, 31, 32, 41, 42, 1, 12, 20, 33, 2047};

    initial begin
        int cnt;
        int unsigned c;
        #1 rst_n = 1'b0;
        #2;
        check("rst_state", state_o, 0);
        check("rst_strobes", {imem_req, ir_write, dmem_req, dmem_we, reg_write, cpsr_write, pc_write}, 0);
        check("rst_sel", {wb_sel, pc_sel}, 0);
        check("rst_flags", {fault, halted}, 0);
        do_reset();

        plan_instr(11'd0, 1, 1, 0, 0, 0);
        check("len_add", ex_q.size(), 4);
        check("add_wb", {ex_q[3].st, ex_q[3].reg_write, ex_q[3].wb_sel, ex_q[3].cpsr_write,
                         ex_q[3].pc_write, ex_q[3].pc_sel}, {3'd4, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0});
        play(100);

        plan_instr(11'd41, 1, 0, 1, 3, 0);
        check("len_ldr", ex_q.size(), 9);
        cnt = 0;
        foreach (ex_q[j]) if (ex_q[j].dmem_req && !ex_q[j].dmem_we) cnt++;
        check("ldr_req_cycles", cnt, 4);
        check("ldr_wb_sel", ex_q[8].wb_sel, 1);
        play(100);

        plan_instr(11'd42, 1, 1, 0, 0, 0);
        check("len_str", ex_q.size(), 4);
        check("str_ack", {ex_q[3].dmem_we, ex_q[3].pc_write, ex_q[3].reg_write}, 3'b110);
        play(100);

        plan_instr(11'd32, 1, 0, 0, 0, 0);
        check("len_bl", ex_q.size(), 3);
        check("bl_exec", {ex_q[2].pc_sel, ex_q[2].reg_write, ex_q[2].wb_sel}, {1'b1, 1'b1, 2'd2});
        play(100);
        plan_instr(11'd32, 0, 0, 0, 0, 0);
        check("bl_skip_exec", {ex_q[2].pc_write, ex_q[2].pc_sel, ex_q[2].reg_write}, 3'b100);
        play(100);
`ifdef CPU_CTRL_PERF_CNT_EN
        check("skipped_after_bl", skipped_cnt, 1);
        check("retired_after_bl", retired_cnt, 4);
`endif

        plan_instr(11'd8, 1, 0, 0, 0, 0);
        check("len_cmp", ex_q.size(), 3);
        check("cmp_exec", {ex_q[2].cpsr_write, ex_q[2].reg_write, ex_q[2].pc_write}, 3'b101);
        play(100);

        plan_instr(11'd20, 1, 1, 0, 0, 0);
        plan_instr(11'd0, 1, 0, 0, 0, 0);
        play(100);
        check("fault_sticky", fault, 1);

        plan_instr(11'd0, 1, 1, 0, 0, 1);
        plan_halt(3);
        plan_instr(11'd6, 1, 0, 0, 0, 0);
        check("len_add_halt_add", ex_q.size(), 4 + 5 + 4);
        play(100);

        do_reset();
        plan_instr(11'd41, 1, 0, 0, 20, 0);
        check("len_timeout", ex_q.size(), 20);
        play(100);
        check("timeout_fault", fault, 1);

        plan_instr(11'd42, 1, 0, 0, 10, 0);
        play(6);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_state", state_o, 0);
        check("async_rst_dmem_req", dmem_req, 0);
        check("async_rst_fault", fault, 0);
        in_q.delete();
        ex_q.delete();
        do_reset();

        for (int n = 0; n < 150; n++) begin
            if (n % 30 == 29) do_reset();
            if ($urandom_range(0, 7) == 0) plan_halt($urandom_range(0, 3));
            c = codes[$urandom_range(0, 20)];
            plan_instr(CODE_W'(c), ($urandom_range(0, 3) != 0), 1'($urandom),
                       $urandom_range(0, 2),
                       ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3), 1'($urandom));
            play(1000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
